ch2_ctrl: RTL and testbench

Sequencing controller for sound channel 2 (pulse channel with envelope, no sweep). It consumes the decoded NR21–NR24 register fields and write strobes from the channel 2 register block, plus frame-sequencer ticks. It runs the frequency timer, duty step, length counter, volume envelope and channel-enable state, and delivers a 4-bit sample to the mixer.

---
 rtl/apu_pkg.sv | 24 ++
 rtl/apu_envelope.sv | 45 ++++
 rtl/ch2_ctrl.sv | 125 ++++++++++++
 tb/tb_ch2_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared APU constants: duty waveforms, length full-scale, frequency timer top.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package apu_pkg;

  // Length counter full-scale (channels 1/2/4).
  localparam int LEN_MAX = 64;

  // Frequency timer overflow value; the reload from freq happens here.
  localparam logic [10:0] FTIMER_MAX = 11'h7FF;

  // Duty waveforms indexed [duty][step]; step 0 is the LSB of each row.
  localparam logic [3:0][7:0] DUTY_PAT = {
    8'b0111_1110,  // duty 3
    8'b1000_0111,  // duty 2
    8'b1000_0001,  // duty 1
    8'b0000_0001   // duty 0
  };

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    return DUTY_PAT[duty][step];
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// Volume envelope: period divider plus saturating 4-bit volume, reloaded on trigger.
// Latency: load/tick take effect on the sampling edge; vol valid the next cycle.
// Backpressure: none; strobes are single-cycle and always accepted.
//
// Ports: clk, napu_reset (async, active low), env_tick (64 Hz strobe),
//        load (trigger: reload vol/etimer), env_init/env_dir/env_period
//        (NRx2 fields), vol (current volume).
module apu_envelope (
  input  logic       clk,
  input  logic       napu_reset,
  input  logic       env_tick,
  input  logic       load,
  input  logic [3:0] env_init,
  input  logic       env_dir,
  input  logic [2:0] env_period,
  output logic [3:0] vol
);
  import apu_pkg::*;

  logic [2:0] etimer;

  always_ff @(posedge clk or negedge napu_reset) begin
    if (!napu_reset) begin
      vol    <= 4'd0;
      etimer <= 3'd0;
    end else if (load) begin
      // Trigger wins over a coincident env_tick.
      vol    <= env_init;
      etimer <= env_period;
    end else if (env_tick && (env_period != 3'd0)) begin
      if (etimer > 3'd1) begin
        etimer <= etimer - 3'd1;
      end else begin
        // Divider expired (or was 0 after a trigger with period 0): reload and step.
        etimer <= env_period;
        if (env_dir && (vol != 4'd15)) begin
          vol <= vol + 4'd1;
        end else if (!env_dir && (vol != 4'd0)) begin
          vol <= vol - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ch2_ctrl.sv
// Channel 2 sequencer: frequency timer, duty step, length, envelope, enable state.
// Latency: every strobe acts on the edge it is sampled; outputs valid next cycle.
// Backpressure: none; register strobes and frame ticks are always accepted.
//
// Ports: clk, napu_reset (async, active low); freq_tick/len_tick/env_tick
//        (enables); duty, len_load, nr21_wr (NR21); env_init, env_dir,
//        env_period, nr22_wr (NR22); freq, len_en, trigger (NR23/NR24);
//        ch2_active, ch2_dac_en, ch2_vol, ch2_duty_bit, ch2_out (status/sample).
module ch2_ctrl #(
  parameter int LEN_MAX = 64
) (
  input  logic        clk,
  input  logic        napu_reset,
  input  logic        freq_tick,
  input  logic        len_tick,
  input  logic        env_tick,
  input  logic [1:0]  duty,
  input  logic [5:0]  len_load,
  input  logic        nr21_wr,
  input  logic [3:0]  env_init,
  input  logic        env_dir,
  input  logic [2:0]  env_period,
  input  logic        nr22_wr,
  input  logic [10:0] freq,
  input  logic        len_en,
  input  logic        trigger,
  output logic        ch2_active,
  output logic        ch2_dac_en,
  output logic [3:0]  ch2_vol,
  output logic        ch2_duty_bit,
  output logic [3:0]  ch2_out
);
  import apu_pkg::*;

  logic [10:0] ftimer;
  logic [2:0]  step;
  logic [6:0]  remaining;
  logic        active_nxt;
  logic [6:0]  len_full;
  logic [6:0]  len_wr_val;
  logic        len_dec;

  // nr22_wr needs no local action: the DAC follows the live NR22 fields and
  // the envelope only reloads on trigger.
  logic unused_nr22_wr;
  assign unused_nr22_wr = nr22_wr;

  assign ch2_dac_en = (env_init != 4'd0) || env_dir;
  assign len_full   = 7'(LEN_MAX);
  assign len_wr_val = len_full - 7'(len_load);
  // A decrement only happens when neither trigger nor an NR21 write owns the counter.
  assign len_dec    = len_tick && len_en && (remaining != 7'd0) && !trigger && !nr21_wr;

  // Frequency timer and duty step; runs whether or not the channel is active.
  always_ff @(posedge clk or negedge napu_reset) begin
    if (!napu_reset) begin
      ftimer <= 11'd0;
      step   <= 3'd0;
    end else if (trigger) begin
      ftimer <= freq;
    end else if (freq_tick) begin
      if (ftimer == FTIMER_MAX) begin
        ftimer <= freq;
        step   <= step + 3'd1;
      end else begin
        ftimer <= ftimer + 11'd1;
      end
    end
  end

  // Length counter.
  always_ff @(posedge clk or negedge napu_reset) begin
    if (!napu_reset) begin
      remaining <= 7'd0;
    end else if (nr21_wr) begin
      // Coincident trigger only substitutes full scale if the write produced 0.
      if (trigger && (len_wr_val == 7'd0)) begin
        remaining <= len_full;
      end else begin
        remaining <= len_wr_val;
      end
    end else if (trigger) begin
      if (remaining == 7'd0) begin
        remaining <= len_full;
      end
    end else if (len_dec) begin
      remaining <= remaining - 7'd1;
    end
  end

  // Channel enable: DAC-off beats trigger, trigger beats length expiry.
  always_comb begin
    active_nxt = ch2_active;
    if (!ch2_dac_en) begin
      active_nxt = 1'b0;
    end else if (trigger) begin
      active_nxt = 1'b1;
    end else if (len_dec && (remaining == 7'd1)) begin
      active_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge napu_reset) begin
    if (!napu_reset) begin
      ch2_active <= 1'b0;
    end else begin
      ch2_active <= active_nxt;
    end
  end

  apu_envelope u_env (
    .clk        (clk),
    .napu_reset (napu_reset),
    .env_tick   (env_tick),
    .load       (trigger),
    .env_init   (env_init),
    .env_dir    (env_dir),
    .env_period (env_period),
    .vol        (ch2_vol)
  );

  assign ch2_duty_bit = duty_bit(duty, step);
  assign ch2_out      = (ch2_active && ch2_duty_bit) ? ch2_vol : 4'd0;

endmodule

// File: tb/tb_ch2_ctrl.sv
// Directed vector bench for ch2_ctrl: table of {strobes, fields, expected outputs}.
// Latency: inputs driven on negedge, outputs compared 1 time unit after posedge.
// Backpressure: n/a.
module tb_ch2_ctrl;

  logic        clk = 1'b0;
  logic        napu_reset = 1'b0;
  logic        freq_tick = 1'b0, len_tick = 1'b0, env_tick = 1'b0;
  logic [1:0]  duty = 2'd0;
  logic [5:0]  len_load = 6'd0;
  logic        nr21_wr = 1'b0;
  logic [3:0]  env_init = 4'd0;
  logic        env_dir = 1'b0;
  logic [2:0]  env_period = 3'd0;
  logic        nr22_wr = 1'b0;
  logic [10:0] freq = 11'd0;
  logic        len_en = 1'b0;
  logic        trigger = 1'b0;
  logic        ch2_active, ch2_dac_en, ch2_duty_bit;
  logic [3:0]  ch2_vol, ch2_out;

  ch2_ctrl #(.LEN_MAX(64)) dut (
    .clk(clk), .napu_reset(napu_reset), .freq_tick(freq_tick), .len_tick(len_tick),
    .env_tick(env_tick), .duty(duty), .len_load(len_load), .nr21_wr(nr21_wr),
    .env_init(env_init), .env_dir(env_dir), .env_period(env_period), .nr22_wr(nr22_wr),
    .freq(freq), .len_en(len_en), .trigger(trigger), .ch2_active(ch2_active),
    .ch2_dac_en(ch2_dac_en), .ch2_vol(ch2_vol), .ch2_duty_bit(ch2_duty_bit), .ch2_out(ch2_out)
  );

  always #5 clk = ~clk;

  // Strobe encoding {trigger, nr21_wr, nr22_wr, freq_tick, len_tick, env_tick}.
  localparam logic [5:0] S_NONE = 6'b000000, S_TRG = 6'b100000, S_N21 = 6'b010000,
                         S_N22 = 6'b001000, S_FT = 6'b000100, S_LT = 6'b000010,
                         S_ET = 6'b000001;

  typedef struct {
    string       nm;
    logic [5:0]  st;
    logic [1:0]  du;
    logic [5:0]  ll;
    logic [3:0]  ei;
    logic        ed;
    logic [2:0]  ep;
    logic [10:0] fq;
    logic        le;
    logic [10:0] ex;   // {active, dac_en, vol, duty_bit, out}
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_miss = 0;

  // Register fields that subsequent add() calls capture.
  logic [1:0]  f_du; logic [5:0] f_ll; logic [3:0] f_ei; logic f_ed;
  logic [2:0]  f_ep; logic [10:0] f_fq; logic f_le;

  task automatic fields(input logic [1:0] du, input logic [5:0] ll, input logic [3:0] ei,
                        input logic ed, input logic [2:0] ep, input logic [10:0] fq,
                        input logic le);
    f_du = du; f_ll = ll; f_ei = ei; f_ed = ed; f_ep = ep; f_fq = fq; f_le = le;
  endtask

  function automatic logic [10:0] ex(input logic a, input logic d, input logic [3:0] v,
                                     input logic b, input logic [3:0] o);
    return {a, d, v, b, o};
  endfunction

  task automatic add(input string nm, input logic [5:0] st, input logic a, input logic d,
                     input logic [3:0] v, input logic b, input logic [3:0] o);
    vec_t x;
    x.nm = nm; x.st = st; x.du = f_du; x.ll = f_ll; x.ei = f_ei; x.ed = f_ed;
    x.ep = f_ep; x.fq = f_fq; x.le = f_le; x.ex = ex(a, d, v, b, o);
    vq.push_back(x);
  endtask

  task automatic check(input string nm, input logic [10:0] want);
    logic [10:0] got;
    got = {ch2_active, ch2_dac_en, ch2_vol, ch2_duty_bit, ch2_out};
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got act=%0b dac=%0b vol=%0d db=%0b out=%0d, want act=%0b dac=%0b vol=%0d db=%0b out=%0d",
               nm, got[10], got[9], got[8:5], got[4], got[3:0],
               want[10], want[9], want[8:5], want[4], want[3:0]);
    end
  endtask

  task automatic apply(input vec_t x);
    @(negedge clk);
    {trigger, nr21_wr, nr22_wr, freq_tick, len_tick, env_tick} = x.st;
    duty = x.du; len_load = x.ll; env_init = x.ei; env_dir = x.ed;
    env_period = x.ep; freq = x.fq; len_en = x.le;
    @(posedge clk);
    #1;
    {trigger, nr21_wr, nr22_wr, freq_tick, len_tick, env_tick} = S_NONE;
    check(x.nm, x.ex);
  endtask

  task automatic run_queue();
    for (int i = 0; i < vq.size(); i++) apply(vq[i]);
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seq_a [8];
    logic [3:0] o;
    seq_a = '{4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};

    // Reset held with every strobe active: state must stay cleared.
    napu_reset = 1'b0;
    duty = 2'd2; env_init = 4'd15; freq = 11'd2046; len_en = 1'b1; env_period = 3'd1;
    {trigger, nr21_wr, nr22_wr, freq_tick, len_tick, env_tick} = 6'b111111;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", ex(1'b0, 1'b1, 4'd0, 1'b1, 4'd0));
    @(negedge clk);
    {trigger, nr21_wr, nr22_wr, freq_tick, len_tick, env_tick} = S_NONE;
    napu_reset = 1'b1;

    // After release: no activity until a trigger.
    fields(2'd3, 6'd0, 4'd0, 1'b0, 3'd0, 11'd0, 1'b0);
    add("post_rst_idle", S_NONE, 0, 0, 4'd0, 0, 4'd0);
    fields(2'd3, 6'd0, 4'd15, 1'b0, 3'd0, 11'd2046, 1'b0);
    add("post_rst_ticks", S_FT | S_LT | S_ET, 0, 1, 4'd0, 0, 4'd0);

    // Duty 2 at freq 2046: step advances every second freq_tick.
    fields(2'd2, 6'd0, 4'd15, 1'b0, 3'd0, 11'd2046, 1'b0);
    add("duty_trig", S_TRG, 1, 1, 4'd15, 1, 4'd15);
    for (int i = 1; i <= 16; i++) begin
      o = seq_a[(i / 2) % 8];
      add($sformatf("duty_ft%0d", i), S_FT, 1, 1, 4'd15, (o != 4'd0), o);
    end
    fields(2'd3, 6'd0, 4'd15, 1'b0, 3'd0, 11'd2046, 1'b0);
    add("duty3_step0", S_NONE, 1, 1, 4'd15, 0, 4'd0);
    fields(2'd1, 6'd0, 4'd15, 1'b0, 3'd0, 11'd2046, 1'b0);
    add("duty1_step0", S_NONE, 1, 1, 4'd15, 1, 4'd15);

    // Length: 64-62 = 2 ticks to expiry, then a re-trigger restores 64.
    fields(2'd2, 6'd62, 4'd15, 1'b0, 3'd0, 11'd2046, 1'b1);
    add("len_wr62", S_N21, 1, 1, 4'd15, 1, 4'd15);
    add("len_trig", S_TRG, 1, 1, 4'd15, 1, 4'd15);
    add("len_tick1", S_LT, 1, 1, 4'd15, 1, 4'd15);
    add("len_tick2", S_LT, 0, 1, 4'd15, 1, 4'd0);
    add("len_retrig", S_TRG, 1, 1, 4'd15, 1, 4'd15);
    for (int i = 1; i <= 63; i++) add($sformatf("len64_t%0d", i), S_LT, 1, 1, 4'd15, 1, 4'd15);
    add("len64_t64", S_LT, 0, 1, 4'd15, 1, 4'd0);

    // Collisions.
    fields(2'd2, 6'd63, 4'd15, 1'b0, 3'd0, 11'd2046, 1'b1);
    add("col_wr63", S_N21, 0, 1, 4'd15, 1, 4'd0);
    add("col_trig", S_TRG, 1, 1, 4'd15, 1, 4'd15);
    add("col_trig_lt", S_TRG | S_LT, 1, 1, 4'd15, 1, 4'd15);
    add("col_lt_after_trig", S_LT, 0, 1, 4'd15, 1, 4'd0);
    add("col_trig2", S_TRG, 1, 1, 4'd15, 1, 4'd15);
    add("col_wr_lt", S_N21 | S_LT, 1, 1, 4'd15, 1, 4'd15);
    add("col_lt_after_wr", S_LT, 0, 1, 4'd15, 1, 4'd0);
    add("col_trig_wr", S_TRG | S_N21, 1, 1, 4'd15, 1, 4'd15);
    add("col_lt_after_trwr", S_LT, 0, 1, 4'd15, 1, 4'd0);
    add("le0_wr63", S_N21, 0, 1, 4'd15, 1, 4'd0);
    add("le0_trig", S_TRG, 1, 1, 4'd15, 1, 4'd15);
    fields(2'd2, 6'd63, 4'd15, 1'b0, 3'd0, 11'd2046, 1'b0);
    add("le0_lt_ignored", S_LT, 1, 1, 4'd15, 1, 4'd15);
    fields(2'd2, 6'd63, 4'd15, 1'b0, 3'd0, 11'd2046, 1'b1);
    add("le1_lt_expire", S_LT, 0, 1, 4'd15, 1, 4'd0);

    // Envelope down, saturating at 0.
    fields(2'd2, 6'd63, 4'd2, 1'b0, 3'd1, 11'd2046, 1'b0);
    add("env_dn_trig", S_TRG, 1, 1, 4'd2, 1, 4'd2);
    add("env_dn_t1", S_ET, 1, 1, 4'd1, 1, 4'd1);
    add("env_dn_t2", S_ET, 1, 1, 4'd0, 1, 4'd0);
    add("env_dn_t3", S_ET, 1, 1, 4'd0, 1, 4'd0);
    // Envelope up, saturating at 15.
    fields(2'd2, 6'd63, 4'd14, 1'b1, 3'd1, 11'd2046, 1'b0);
    add("env_up_trig", S_TRG, 1, 1, 4'd14, 1, 4'd14);
    add("env_up_t1", S_ET, 1, 1, 4'd15, 1, 4'd15);
    add("env_up_t2", S_ET, 1, 1, 4'd15, 1, 4'd15);
    add("env_up_t3", S_ET, 1, 1, 4'd15, 1, 4'd15);
    // Period 2: volume steps on every second env_tick.
    fields(2'd2, 6'd63, 4'd14, 1'b1, 3'd2, 11'd2046, 1'b0);
    add("env_p2_trig", S_TRG, 1, 1, 4'd14, 1, 4'd14);
    add("env_p2_t1", S_ET, 1, 1, 4'd14, 1, 4'd14);
    add("env_p2_t2", S_ET, 1, 1, 4'd15, 1, 4'd15);
    // Period 0 freezes the envelope; NR22 write does not reload vol.
    fields(2'd2, 6'd63, 4'd8, 1'b0, 3'd0, 11'd2046, 1'b0);
    add("env_p0_trig", S_TRG, 1, 1, 4'd8, 1, 4'd8);
    add("env_p0_tick", S_ET, 1, 1, 4'd8, 1, 4'd8);
    fields(2'd2, 6'd63, 4'd3, 1'b0, 3'd0, 11'd2046, 1'b0);
    add("nr22_no_reload", S_N22, 1, 1, 4'd8, 1, 4'd8);

    // DAC off clears active; trigger with DAC off reloads but stays inactive.
    fields(2'd2, 6'd63, 4'd0, 1'b0, 3'd0, 11'd2046, 1'b0);
    add("dac_off", S_N22, 0, 0, 4'd8, 1, 4'd0);
    add("dac_off_trig", S_TRG, 0, 0, 4'd0, 1, 4'd0);
    fields(2'd2, 6'd63, 4'd0, 1'b1, 3'd0, 11'd2046, 1'b0);
    add("dac_dir_trig", S_TRG, 1, 1, 4'd0, 1, 4'd0);

    fields(2'd2, 6'd63, 4'd9, 1'b0, 3'd0, 11'd2046, 1'b0);
    add("mo_trig", S_TRG, 1, 1, 4'd9, 1, 4'd9);
    run_queue();

    // Mid-operation asynchronous reset, checked before any clock edge.
    @(negedge clk);
    #2 napu_reset = 1'b0;
    #1 check("mo_rst_async", ex(1'b0, 1'b1, 4'd0, 1'b1, 4'd0));
    @(negedge clk);
    napu_reset = 1'b1;
    add("mo_post_ticks", S_FT | S_LT | S_ET, 0, 1, 4'd0, 1, 4'd0);
    add("mo_retrig", S_TRG, 1, 1, 4'd9, 1, 4'd9);
    run_queue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
